// File: rtl/serial_frame_detector.sv
// serial_frame_detector: frame-extraction stage on the serial receive path.
// It looks for the start pattern 1101 (oldest bit first) in a 1-bit stream and then
// forwards the next PAYLOAD_LEN bits with a valid strobe.
// The file holds three modules:
//   serdet_fsm      - start-pattern detector and payload-window FSM
//   serdet_counter  - 4-bit payload position counter
//   serial_frame_detector (top) - links the two through inc_cnt / rst_cnt / Co
//
// Top ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   Clk_EN       in   clock enable; every register holds while low
//   SerIn        in   serial data
//   SerOut       out  forwarded payload bit (0 outside the payload window)
//   SerOutValid  out  high during the PAYLOAD_LEN payload cycles
//   Count_out    out  payload counter value
//
// Optional feature macro: SERDET_COUNT_HOLD_EN
//   defined   - the counter is cleared only when a frame starts, so Count_out keeps
//               PAYLOAD_LEN-1 between frames
//   undefined - the counter is also cleared while searching, so Count_out returns
//               to 0 one enabled edge after a frame

// Detector FSM. Its outputs are Mealy: SerOut follows SerIn in PAYLOAD with zero latency.
module serdet_fsm (
    input  logic clk,
    input  logic rst,
    input  logic Clk_EN,
    input  logic SerIn,
    input  logic Co,
    output logic SerOut,
    output logic SerOutValid,
    output logic inc_cnt,
    output logic rst_cnt
);

    typedef enum logic [2:0] {
        StS0,
        StS1,
        StS11,
        StS110,
        StPayload
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StS0;
        end else if (Clk_EN) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        SerOut      = 1'b0;
        SerOutValid = 1'b0;
        inc_cnt     = 1'b0;
        rst_cnt     = 1'b0;
        unique case (state_q)
            StS0: begin
                if (SerIn) state_d = StS1;
`ifndef SERDET_COUNT_HOLD_EN
                rst_cnt = 1'b1;
`endif
            end
            StS1: begin
                state_d = SerIn ? StS11 : StS0;
`ifndef SERDET_COUNT_HOLD_EN
                rst_cnt = 1'b1;
`endif
            end
            StS11: begin
                // A run of 1s keeps the "11" prefix alive.
                state_d = SerIn ? StS11 : StS110;
`ifndef SERDET_COUNT_HOLD_EN
                rst_cnt = 1'b1;
`endif
            end
            StS110: begin
                if (SerIn) begin
                    state_d = StPayload;
                    // Counter enters PAYLOAD at 0.
                    rst_cnt = 1'b1;
                end else begin
                    state_d = StS0;
                end
            end
            StPayload: begin
                SerOutValid = 1'b1;
                SerOut      = SerIn;
                // Counter stops at PAYLOAD_LEN-1 on the last payload cycle.
                inc_cnt     = ~Co;
                if (Co) state_d = StS0;
            end
            default: begin
                state_d = StS0;
            end
        endcase
    end

endmodule

// Payload position counter; a clear request wins over an increment.
module serdet_counter #(
    parameter int unsigned PAYLOAD_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Clk_EN,
    input  logic       inc_cnt,
    input  logic       rst_cnt,
    output logic       Co,
    output logic [3:0] Count_out
);

    localparam logic [3:0] LastIdx = 4'(PAYLOAD_LEN - 1);

    logic [3:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 4'd0;
        end else if (Clk_EN) begin
            if (rst_cnt) begin
                count_q <= 4'd0;
            end else if (inc_cnt) begin
                count_q <= count_q + 4'd1;
            end
        end
    end

    assign Co        = (count_q == LastIdx);
    assign Count_out = count_q;

endmodule

module serial_frame_detector #(
    parameter int unsigned PAYLOAD_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Clk_EN,
    input  logic       SerIn,
    output logic       SerOut,
    output logic       SerOutValid,
    output logic [3:0] Count_out
);

    logic inc_cnt;
    logic rst_cnt;
    logic Co;

    serdet_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .Clk_EN      (Clk_EN),
        .SerIn       (SerIn),
        .Co          (Co),
        .SerOut      (SerOut),
        .SerOutValid (SerOutValid),
        .inc_cnt     (inc_cnt),
        .rst_cnt     (rst_cnt)
    );

    serdet_counter #(
        .PAYLOAD_LEN (PAYLOAD_LEN)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .Clk_EN    (Clk_EN),
        .inc_cnt   (inc_cnt),
        .rst_cnt   (rst_cnt),
        .Co        (Co),
        .Count_out (Count_out)
    );

endmodule

// File: tb/tb_serial_frame_detector.sv
// Scoreboard bench for serial_frame_detector.
// The driver drives inputs on the falling clock edge. It then pushes the outputs that are
// expected for that cycle, which it takes from a bit-history reference model. The monitor
// compares the DUT outputs shortly after every falling edge.
module tb_serial_frame_detector;

    localparam int unsigned LEN = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       Clk_EN = 1'b0;
    logic       SerIn  = 1'b0;
    logic       SerOut;
    logic       SerOutValid;
    logic [3:0] Count_out;

    serial_frame_detector #(
        .PAYLOAD_LEN (LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Clk_EN      (Clk_EN),
        .SerIn       (SerIn),
        .SerOut      (SerOut),
        .SerOutValid (SerOutValid),
        .Count_out   (Count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       d;
        logic [3:0] c;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int beats_exp  = 0;
    int beats_seen = 0;

    // Reference model: recent bits seen while searching, and the payload position
    // (-1 = searching). cnt_model is the counter value shown while searching.
    bit hist[$];
    int pay_idx   = -1;
    int cnt_model = 0;

    task automatic model_reset();
        hist.delete();
        pay_idx   = -1;
        cnt_model = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.cyc = cyc;
        if (!rst) begin
            e.v = 1'b0; e.d = 1'b0; e.c = 4'd0;
        end else if (pay_idx >= 0) begin
            e.v = 1'b1; e.d = SerIn; e.c = 4'(pay_idx);
        end else begin
            e.v = 1'b0; e.d = 1'b0; e.c = 4'(cnt_model);
        end
        if (e.v) beats_exp++;
        q.push_back(e);
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_edge();
        if (!rst || !Clk_EN) return;
        if (pay_idx >= 0) begin
            if (pay_idx == int'(LEN) - 1) begin
                pay_idx   = -1;
                cnt_model = int'(LEN) - 1;
                hist.delete();
            end else begin
                pay_idx++;
            end
        end else begin
            hist.push_back(SerIn);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] && hist[1] && !hist[2] && hist[3]) begin
                pay_idx = 0;
                hist.delete();
            end else begin
`ifndef SERDET_COUNT_HOLD_EN
                cnt_model = 0;
`endif
            end
        end
    endtask

    task automatic drive(input logic en, input logic si, input logic rs);
        @(negedge clk);
        cyc++;
        rst    = rs;
        Clk_EN = en;
        SerIn  = si;
        if (!rs) model_reset();
        push_exp();
        model_edge();
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) drive(1'b1, b[i], 1'b1);
    endtask

    // Monitor: checks the DUT against the expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (SerOutValid !== e.v) begin
                    failures++;
                    $display("FAIL valid cyc=%0d got=%b exp=%b", e.cyc, SerOutValid, e.v);
                end
                checks++;
                if (SerOut !== e.d) begin
                    failures++;
                    $display("FAIL serout cyc=%0d got=%b exp=%b", e.cyc, SerOut, e.d);
                end
                checks++;
                if (Count_out !== e.c) begin
                    failures++;
                    $display("FAIL count cyc=%0d got=%0d exp=%0d", e.cyc, Count_out, e.c);
                end
                if (SerOutValid === 1'b1) beats_seen++;
            end
        end
    end

    initial begin
        model_reset();
        // Held in reset for a few cycles.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
        // Reset release with idle zeros.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1);
        // Basic frame: 0,0,1,0,1,1,1,0,1 then payload 1,1,1,1, then idle.
        send_bits(16'b0_0101_1101, 9);
        send_bits(16'b1111, 4);
        send_bits(16'b000, 3);
        // No false trigger.
        send_bits(16'b1011_1000, 8);
        // Overlap: 1,1,1,1,0,1 then payload 0,1,0,1.
        send_bits(16'b11_1101, 6);
        send_bits(16'b0101, 4);
        send_bits(16'b00, 2);
        // Clock-enable freeze after the 2nd payload bit.
        send_bits(16'b1101, 4);
        send_bits(16'b10, 2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'(i), 1'b1);
        send_bits(16'b11, 2);
        send_bits(16'b000, 3);
        // Asynchronous reset mid-payload, asserted between edges.
        send_bits(16'b1101, 4);
        send_bits(16'b1, 1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        // After release a fresh 1101 is required.
        send_bits(16'b1011_0100, 8);
        // Same patterns with an idle enable while searching.
        drive(1'b0, 1'b1, 1'b1);
        send_bits(16'b1101_0110, 8);
        // Randomized traffic biased toward 1s so frames occur often.
        for (int i = 0; i < 3000; i++) begin
            logic en;
            logic si;
            logic rs;
            en = ($urandom_range(0, 99) < 85);
            si = ($urandom_range(0, 99) < 60);
            rs = ($urandom_range(0, 249) != 0);
            drive(en, si, rs);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #3;
        checks++;
        if (beats_seen != beats_exp) begin
            failures++;
            $display("FAIL beats got=%0d exp=%0d", beats_seen, beats_exp);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
